// File: rtl/bcd_score_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_score_counter
// Purpose  : Packed-BCD score accumulator for the whack-a-mole game.
//            Single-cycle N-digit BCD add/subtract. Increments saturate at
//            all-9s and raise a sticky overflow flag. Decrements stop at a
//            floor of zero. Includes a synchronous clear for a new round.
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous active-low reset
//            clr        - synchronous clear of score and ovf
//            inc        - add INC_STEP this cycle (successful hit)
//            dec        - subtract DEC_STEP this cycle (miss/penalty)
//            score      - packed BCD, digit k at [4k+3:4k]
//            zero       - score == 0 (combinational from register)
//            sat        - score == all 9s (combinational from register)
//            ovf        - sticky: an inc was clipped since last clr/reset
//            high_score - best score since reset (only with
//                         BCD_SCORE_HIGH_SCORE_EN defined)
// Options  : define BCD_SCORE_HIGH_SCORE_EN to add the high-score register
// Revision : 1.0 - initial release
// ============================================================================
module bcd_score_counter #(
    parameter int DIGITS   = 4,
    parameter int INC_STEP = 1,
    parameter int DEC_STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    input  logic                  dec,
    output logic [4*DIGITS-1:0]   score,
    output logic                  zero,
    output logic                  sat,
    output logic                  ovf
`ifdef BCD_SCORE_HIGH_SCORE_EN
    ,
    output logic [4*DIGITS-1:0]   high_score
`endif
);

    localparam int              c_W         = 4 * DIGITS;
    localparam logic [c_W-1:0]  c_ALL_NINES = {DIGITS{4'h9}};
    localparam logic [4:0]      c_INC_STEP  = 5'(INC_STEP);
    localparam logic [4:0]      c_DEC_STEP  = 5'(DEC_STEP);

    logic [c_W-1:0] r_score;
    logic           r_ovf;
    logic [c_W-1:0] w_sum;
    logic [c_W-1:0] w_diff;
    logic           w_carry_out;
    logic           w_borrow_out;
    logic [c_W-1:0] w_score_nxt;
    logic           w_ovf_nxt;

    // ------------------------------------------------------------------
    // BCD ripple-carry add of the increment step into the units digit.
    // Units can reach 9+9=18, upper digits at most 9+1=10, so one -10
    // correction per digit is always enough.
    // ------------------------------------------------------------------
    always_comb begin : p_add
        logic       carry;
        logic [4:0] d;
        w_sum = '0;
        carry = 1'b0;
        d     = '0;
        for (int k = 0; k < DIGITS; k++) begin
            d = {1'b0, r_score[4*k +: 4]} + {4'b0, carry}
              + ((k == 0) ? c_INC_STEP : 5'd0);
            if (d > 5'd9) begin
                w_sum[4*k +: 4] = 4'(d - 5'd10);
                carry           = 1'b1;
            end else begin
                w_sum[4*k +: 4] = d[3:0];
                carry           = 1'b0;
            end
        end
        w_carry_out = carry;
    end

    // ------------------------------------------------------------------
    // BCD ripple-borrow subtract of the decrement step from the units.
    // ------------------------------------------------------------------
    always_comb begin : p_sub
        logic       borrow;
        logic [4:0] sub;
        logic [4:0] dig;
        w_diff = '0;
        borrow = 1'b0;
        sub    = '0;
        dig    = '0;
        for (int k = 0; k < DIGITS; k++) begin
            sub = ((k == 0) ? c_DEC_STEP : 5'd0) + {4'b0, borrow};
            dig = {1'b0, r_score[4*k +: 4]};
            if (dig < sub) begin
                w_diff[4*k +: 4] = 4'(dig + 5'd10 - sub);
                borrow           = 1'b1;
            end else begin
                w_diff[4*k +: 4] = 4'(dig - sub);
                borrow           = 1'b0;
            end
        end
        w_borrow_out = borrow;
    end

    // ------------------------------------------------------------------
    // Next-state selection: clr > (inc & dec) > inc > dec > hold.
    // A carry out of the top digit (which also covers inc at all-9s)
    // clamps to all-9s; a borrow out of the top digit clamps to zero.
    // ------------------------------------------------------------------
    always_comb begin : p_next
        w_score_nxt = r_score;
        w_ovf_nxt   = r_ovf;
        if (clr) begin
            w_score_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else if (inc && dec) begin
            w_score_nxt = r_score;
        end else if (inc) begin
            if (w_carry_out) begin
                w_score_nxt = c_ALL_NINES;
                w_ovf_nxt   = 1'b1;
            end else begin
                w_score_nxt = w_sum;
            end
        end else if (dec) begin
            w_score_nxt = w_borrow_out ? '0 : w_diff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            r_score <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_score <= w_score_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign score = r_score;
    assign ovf   = r_ovf;
    assign zero  = (r_score == '0);
    assign sat   = (r_score == c_ALL_NINES);

`ifdef BCD_SCORE_HIGH_SCORE_EN
    logic [c_W-1:0] r_high;
    logic           w_new_high;

    // Magnitude compare, most significant digit first: the first digit
    // that differs decides the result.
    always_comb begin : p_high_cmp
        logic decided;
        decided    = 1'b0;
        w_new_high = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (!decided && (w_score_nxt[4*k +: 4] != r_high[4*k +: 4])) begin
                w_new_high = (w_score_nxt[4*k +: 4] > r_high[4*k +: 4]);
                decided    = 1'b1;
            end
        end
    end

    // Compares against the next score so the record moves on the same
    // edge as the score itself; clr never raises it (next score is 0).
    always_ff @(posedge clk or negedge rst_n) begin : p_high_reg
        if (!rst_n) begin
            r_high <= '0;
        end else if (w_new_high) begin
            r_high <= w_score_nxt;
        end
    end

    assign high_score = r_high;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_score_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_score_counter
// Purpose  : Self-checking bench for bcd_score_counter. Two instances:
//            u0 (DIGITS=4, INC_STEP=1, DEC_STEP=1) and
//            u1 (DIGITS=4, INC_STEP=7, DEC_STEP=1). Each is tracked by an
//            integer-valued score model that is compared every cycle, plus
//            directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_score_counter;

    localparam int MAXV = 9999;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr0 = 1'b0, inc0 = 1'b0, dec0 = 1'b0;
    logic        clr1 = 1'b0, inc1 = 1'b0, dec1 = 1'b0;
    logic [15:0] score0, score1;
    logic        zero0, sat0, ovf0, zero1, sat1, ovf1;
    logic [15:0] high0, high1;

    int n_checks = 0;
    int n_err    = 0;

    // model state
    int m0 = 0, m1 = 0, mh0 = 0, mh1 = 0;
    bit mo0 = 0, mo1 = 0;

    always #5 clk = ~clk;

    bcd_score_counter #(.DIGITS(4), .INC_STEP(1), .DEC_STEP(1)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr0), .inc(inc0), .dec(dec0),
        .score(score0), .zero(zero0), .sat(sat0), .ovf(ovf0)
`ifdef BCD_SCORE_HIGH_SCORE_EN
        , .high_score(high0)
`endif
    );

    bcd_score_counter #(.DIGITS(4), .INC_STEP(7), .DEC_STEP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1), .inc(inc1), .dec(dec1),
        .score(score1), .zero(zero1), .sat(sat1), .ovf(ovf1)
`ifdef BCD_SCORE_HIGH_SCORE_EN
        , .high_score(high1)
`endif
    );

`ifndef BCD_SCORE_HIGH_SCORE_EN
    assign high0 = '0;
    assign high1 = '0;
`endif

    // ---------------- helpers ----------------
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit legal_bcd(input logic [15:0] s);
        for (int k = 0; k < 4; k++)
            if (s[4*k +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int nxt_val(input int v, input bit c, input bit i,
                                   input bit d, input int su, input int sd);
        if (c) return 0;
        if (i && d) return v;
        if (i) return (v + su > MAXV) ? MAXV : v + su;
        if (d) return (v < sd) ? 0 : v - sd;
        return v;
    endfunction

    function automatic bit nxt_ovf(input int v, input bit o, input bit c,
                                   input bit i, input bit d, input int su);
        if (c) return 1'b0;
        if (i && !d && (v + su > MAXV)) return 1'b1;
        return o;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= 0; mo0 <= 1'b0; mh0 <= 0;
            m1 <= 0; mo1 <= 1'b0; mh1 <= 0;
        end else begin
            m0  <= nxt_val(m0, clr0, inc0, dec0, 1, 1);
            mo0 <= nxt_ovf(m0, mo0, clr0, inc0, dec0, 1);
            mh0 <= imax(mh0, nxt_val(m0, clr0, inc0, dec0, 1, 1));
            m1  <= nxt_val(m1, clr1, inc1, dec1, 7, 1);
            mo1 <= nxt_ovf(m1, mo1, clr1, inc1, dec1, 7);
            mh1 <= imax(mh1, nxt_val(m1, clr1, inc1, dec1, 7, 1));
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("u0.score", 32'(score0), 32'(to_bcd(m0)));
            chk("u0.zero",  32'(zero0),  32'(m0 == 0));
            chk("u0.sat",   32'(sat0),   32'(m0 == MAXV));
            chk("u0.ovf",   32'(ovf0),   32'(mo0));
            chk("u0.digits_legal", 32'(legal_bcd(score0)), 32'd1);
            chk("u1.score", 32'(score1), 32'(to_bcd(m1)));
            chk("u1.zero",  32'(zero1),  32'(m1 == 0));
            chk("u1.sat",   32'(sat1),   32'(m1 == MAXV));
            chk("u1.ovf",   32'(ovf1),   32'(mo1));
            chk("u1.digits_legal", 32'(legal_bcd(score1)), 32'd1);
`ifdef BCD_SCORE_HIGH_SCORE_EN
            chk("u0.high", 32'(high0), 32'(to_bcd(mh0)));
            chk("u1.high", 32'(high1), 32'(to_bcd(mh1)));
`endif
        end
    end

    // ---------------- stimulus ----------------
    // Drive both instances' inputs, let one rising edge pass, return 1 ns later.
    task automatic cyc(input bit c0, input bit i0, input bit d0,
                       input bit c1, input bit i1, input bit d1);
        clr0 = c0; inc0 = i0; dec0 = d0;
        clr1 = c1; inc1 = i1; dec1 = d1;
        @(posedge clk);
        #1;
        clr0 = 1'b0; inc0 = 1'b0; dec0 = 1'b0;
        clr1 = 1'b0; inc1 = 1'b0; dec1 = 1'b0;
    endtask

    task automatic inc0_n(input int n);
        for (int k = 0; k < n; k++) cyc(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        // reset
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset.score", 32'(score0), 32'h0);
        chk("reset.zero",  32'(zero0),  32'h1);
        chk("reset.ovf",   32'(ovf0),   32'h0);
        chk("reset.high",  32'(high0),  32'h0);

        // count up 1000 times with milestone checks
        for (int n = 1; n <= 1000; n++) begin
            cyc(0, 1, 0, 0, 0, 0);
            if (n == 1)    chk("up.zero_after_first", 32'(zero0), 32'h0);
            if (n == 9)    chk("up.9",    32'(score0), 32'h0009);
            if (n == 10)   chk("up.10",   32'(score0), 32'h0010);
            if (n == 100)  chk("up.100",  32'(score0), 32'h0100);
            if (n == 1000) chk("up.1000", 32'(score0), 32'h1000);
        end

        // saturation and sticky overflow
        inc0_n(8998);
        chk("sat.pre", 32'(score0), 32'h9998);
        cyc(0, 1, 0, 0, 0, 0);
        chk("sat.9999", 32'(score0), 32'h9999);
        chk("sat.flag", 32'(sat0),   32'h1);
        chk("sat.ovf_not_yet", 32'(ovf0), 32'h0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("sat.hold1", 32'(score0), 32'h9999);
        chk("sat.ovf1",  32'(ovf0),   32'h1);
        cyc(0, 1, 0, 0, 0, 0);
        chk("sat.hold2", 32'(score0), 32'h9999);
        cyc(0, 0, 0, 0, 0, 0);
        chk("sat.ovf_sticky", 32'(ovf0), 32'h1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("clr.score", 32'(score0), 32'h0000);
        chk("clr.ovf",   32'(ovf0),   32'h0);
        chk("clr.zero",  32'(zero0),  32'h1);

        // decrement with borrow and zero floor
        inc0_n(100);
        cyc(0, 0, 1, 0, 0, 0);
        chk("dec.0099", 32'(score0), 32'h0099);
        for (int k = 0; k < 99; k++) cyc(0, 0, 1, 0, 0, 0);
        chk("dec.zero", 32'(score0), 32'h0000);
        cyc(0, 0, 1, 0, 0, 0);
        chk("dec.floor", 32'(score0), 32'h0000);
        chk("dec.floor_ovf", 32'(ovf0), 32'h0);

        // inc and dec together, clr priority
        inc0_n(42);
        for (int k = 0; k < 5; k++) cyc(0, 1, 1, 0, 0, 0);
        chk("both.hold", 32'(score0), 32'h0042);
        cyc(1, 1, 0, 0, 0, 0);
        chk("clr_over_inc", 32'(score0), 32'h0000);

        // step of 7 on u1
        cyc(0, 0, 0, 0, 1, 0);
        chk("u1.7", 32'(score1), 32'h0007);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("u1.5", 32'(score1), 32'h0005);
        cyc(0, 0, 0, 0, 1, 0);
        chk("u1.12", 32'(score1), 32'h0012);
        cyc(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 143; k++) cyc(0, 0, 0, 0, 1, 0);
        chk("u1.1001", 32'(score1), 32'h1001);
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 0, 1);
        chk("u1.0995", 32'(score1), 32'h0995);
        cyc(0, 0, 0, 0, 1, 0);
        chk("u1.1002", 32'(score1), 32'h1002);

        // randomized traffic, checked by the model every cycle
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(63) == 0), ($urandom_range(99) < 55), ($urandom_range(99) < 30),
                ($urandom_range(63) == 0), ($urandom_range(99) < 50), ($urandom_range(99) < 40));
        end

        // async reset between edges, no clock needed
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.score0", 32'(score0), 32'h0);
        chk("areset.score1", 32'(score1), 32'h0);
        chk("areset.ovf0",   32'(ovf0),   32'h0);
        chk("areset.high0",  32'(high0),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // high score survives clr and tracks on the same edge
        inc0_n(150);
        cyc(1, 0, 0, 0, 0, 0);
        inc0_n(120);
        chk("hs.score120", 32'(score0), 32'h0120);
`ifdef BCD_SCORE_HIGH_SCORE_EN
        chk("hs.keep150", 32'(high0), 32'h0150);
`endif
        inc0_n(31);
        chk("hs.score151", 32'(score0), 32'h0151);
`ifdef BCD_SCORE_HIGH_SCORE_EN
        chk("hs.151", 32'(high0), 32'h0151);
`endif

        // reset mid-sequence with inc held high
        inc0 = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("areset2.score0", 32'(score0), 32'h0);
        chk("areset2.ovf0",   32'(ovf0),   32'h0);
        chk("areset2.high0",  32'(high0),  32'h0);
        inc0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1, 0, 0, 0, 0);
        chk("post_reset.first_edge", 32'(score0), 32'h0001);
        cyc(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
